// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, CTRL layout and
// the byte-lane merge used by every writable register.
package mmio_pkg;

  localparam logic [7:0] OFF_LED     = 8'h00;
  localparam logic [7:0] OFF_CTRL    = 8'h04;
  localparam logic [7:0] OFF_COUNT   = 8'h08;
  localparam logic [7:0] OFF_RELOAD  = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH = 8'h10;
  localparam logic [7:0] OFF_CYCLE   = 8'h14;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_PEND = 2;

  // Field order matches the CTRL register bit layout (pend is bit 2).
  typedef struct packed {
    logic pend;
    logic auto_rl;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Down-counting timer with one-shot / auto-reload modes and a sticky pending flag.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_count,
  input  logic        i_wr_reload,
  input  logic        i_wr_ctrl,
  input  logic [31:0] i_count_wd,
  input  logic [31:0] i_reload_wd,
  input  logic [2:0]  i_ctrl_wd,
  output logic [31:0] o_count,
  output logic [31:0] o_reload,
  output ctrl_t       o_ctrl,
  output logic        o_irq
);

  logic [31:0] r_count, r_reload, w_count_nxt;
  logic        r_en, r_auto, r_pend;
  logic        w_en_nxt, w_auto_nxt, w_pend_nxt, w_expire;

  always_comb begin
    w_count_nxt = r_count;
    w_en_nxt    = r_en;
    w_auto_nxt  = r_auto;
    w_pend_nxt  = r_pend;
    w_expire    = 1'b0;

    if (i_wr_count) begin
      w_count_nxt = i_count_wd;
    end else if (r_en && (r_count == 32'd0)) begin
      w_expire = 1'b1;
      // r_reload is the pre-edge value, so a coincident RELOAD write is not seen here.
      if (r_auto) w_count_nxt = r_reload;
    end else if (r_en) begin
      w_count_nxt = r_count - 32'd1;
    end

    if (i_wr_ctrl) begin
      w_en_nxt   = i_ctrl_wd[CTRL_EN];
      w_auto_nxt = i_ctrl_wd[CTRL_AUTO];
      if (i_ctrl_wd[CTRL_PEND]) w_pend_nxt = 1'b0;
    end

    // Expiry overrides a simultaneous software clear and EN write.
    if (w_expire) begin
      w_pend_nxt = 1'b1;
      if (!r_auto) w_en_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= 32'd0;
      r_reload <= 32'd0;
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_en    <= w_en_nxt;
      r_auto  <= w_auto_nxt;
      r_pend  <= w_pend_nxt;
      if (i_wr_reload) r_reload <= i_reload_wd;
    end
  end

  assign o_count        = r_count;
  assign o_reload       = r_reload;
  assign o_ctrl.pend    = r_pend;
  assign o_ctrl.auto_rl = r_auto;
  assign o_ctrl.en      = r_en;
  assign o_irq          = r_pend;

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder beside dmem: decodes a 256-byte window and serves LED, CTRL,
// COUNT, RELOAD, SCRATCH and CYCLE with combinational reads and edge-committed writes.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LED_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [3:0]           byteEnable,
  input  logic [31:0]          a,
  input  logic [31:0]          wd,
  output logic [31:0]          rd,
  output logic                 hit,
  output logic                 irq,
  output logic [LED_WIDTH-1:0] LED
);

  logic                 w_reg_acc, w_wr;
  logic [7:0]           w_off;
  logic                 w_wr_led, w_wr_ctrl, w_wr_count, w_wr_reload, w_wr_scratch;
  logic [LED_WIDTH-1:0] r_led, w_led_nxt;
  logic [31:0]          r_scratch, r_cycle;
  logic [31:0]          w_led_ext, w_count, w_reload;
  ctrl_t                w_ctrl;

  assign hit       = (a[31:8] == BASE_ADDR[31:8]);
  assign w_reg_acc = hit && (a[1:0] == 2'b00);
  assign w_off     = a[7:0];
  assign w_wr      = we && w_reg_acc && (byteEnable != 4'b0000);

  assign w_wr_led     = w_wr && (w_off == OFF_LED);
  assign w_wr_ctrl    = w_wr && (w_off == OFF_CTRL) && byteEnable[0];
  assign w_wr_count   = w_wr && (w_off == OFF_COUNT);
  assign w_wr_reload  = w_wr && (w_off == OFF_RELOAD);
  assign w_wr_scratch = w_wr && (w_off == OFF_SCRATCH);

  always_comb begin
    w_led_nxt = r_led;
    for (int i = 0; i < LED_WIDTH; i++) begin
      if (byteEnable[i / 8]) w_led_nxt[i] = wd[i];
    end
  end

  always_comb begin
    w_led_ext                = 32'd0;
    w_led_ext[LED_WIDTH-1:0] = r_led;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led     <= '0;
      r_scratch <= 32'd0;
      r_cycle   <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_wr_led)     r_led     <= w_led_nxt;
      if (w_wr_scratch) r_scratch <= byte_merge(r_scratch, wd, byteEnable);
    end
  end

  mmio_timer u_timer (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_wr_count  (w_wr_count),
    .i_wr_reload (w_wr_reload),
    .i_wr_ctrl   (w_wr_ctrl),
    .i_count_wd  (byte_merge(w_count, wd, byteEnable)),
    .i_reload_wd (byte_merge(w_reload, wd, byteEnable)),
    .i_ctrl_wd   (wd[2:0]),
    .o_count     (w_count),
    .o_reload    (w_reload),
    .o_ctrl      (w_ctrl),
    .o_irq       (irq)
  );

  always_comb begin
    rd = 32'd0;
    if (w_reg_acc) begin
      case (w_off)
        OFF_LED:     rd = w_led_ext;
        OFF_CTRL:    rd = {29'd0, w_ctrl};
        OFF_COUNT:   rd = w_count;
        OFF_RELOAD:  rd = w_reload;
        OFF_SCRATCH: rd = r_scratch;
        OFF_CYCLE:   rd = r_cycle;
        default:     rd = 32'd0;
      endcase
    end
  end

  assign LED = r_led;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: a register-level reference model checked every
// cycle, plus directed sequences with hand-computed expectations.
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_LED = BASE + 32'h00, A_CTRL = BASE + 32'h04, A_COUNT = BASE + 32'h08;
  localparam logic [31:0] A_RELOAD = BASE + 32'h0C, A_SCRATCH = BASE + 32'h10;
  localparam logic [31:0] A_CYCLE = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  byteEnable = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        hit, irq;
  logic [3:0]  LED;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_responder #(
    .BASE_ADDR (BASE),
    .LED_WIDTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .byteEnable (byteEnable),
    .a          (a),
    .wd         (wd),
    .rd         (rd),
    .hit        (hit),
    .irq        (irq),
    .LED        (LED)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] led, scratch, cycle, count, reload;
    logic        en, autorl, pend;
  } model_t;

  model_t m = '{default: '0};

  function automatic model_t step(model_t s, logic w, logic [3:0] be, logic [31:0] ad,
                                  logic [31:0] d);
    model_t      n;
    logic [31:0] mask;
    logic        acc, cw, ctrl_w, expire;
    n      = s;
    mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    acc    = w && (ad[31:8] == BASE[31:8]) && (ad[1:0] == 2'b00) && (be != 4'd0);
    cw     = acc && (ad[7:0] == 8'h08);
    ctrl_w = acc && (ad[7:0] == 8'h04) && be[0];
    expire = !cw && s.en && (s.count == 32'd0);
    n.cycle = s.cycle + 32'd1;
    if (acc && ad[7:0] == 8'h00) n.led = ((s.led & ~mask) | (d & mask)) & 32'hF;
    if (acc && ad[7:0] == 8'h10) n.scratch = (s.scratch & ~mask) | (d & mask);
    if (acc && ad[7:0] == 8'h0C) n.reload = (s.reload & ~mask) | (d & mask);
    if (cw) n.count = (s.count & ~mask) | (d & mask);
    else if (expire) n.count = s.autorl ? s.reload : s.count;
    else if (s.en) n.count = s.count - 32'd1;
    if (ctrl_w) begin
      n.en     = d[0];
      n.autorl = d[1];
      if (d[2]) n.pend = 1'b0;
    end
    if (expire) begin
      n.pend = 1'b1;
      if (!s.autorl) n.en = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [31:0] m_read(model_t s, logic [31:0] ad);
    if (ad[31:8] != BASE[31:8] || ad[1:0] != 2'b00) return 32'd0;
    case (ad[7:0])
      8'h00:   return s.led;
      8'h04:   return {29'd0, s.pend, s.autorl, s.en};
      8'h08:   return s.count;
      8'h0C:   return s.reload;
      8'h10:   return s.scratch;
      8'h14:   return s.cycle;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '{default: '0};
    else        m <= step(m, we, byteEnable, a, wd);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_rd", rd, m_read(m, a));
    check("model_hit", {31'd0, hit}, {31'd0, a[31:8] == BASE[31:8]});
    check("model_irq", {31'd0, irq}, {31'd0, m.pend});
    check("model_led", {28'd0, LED}, m.led);
  end

  task automatic cyc(input logic w, input logic [31:0] ad, input logic [31:0] d,
                     input logic [3:0] b);
    we = w; a = ad; wd = d; byteEnable = b;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] ad, input logic [31:0] exp);
    we = 1'b0; a = ad; byteEnable = 4'd0;
    #1;
    check(name, rd, exp);
  endtask

  initial begin
    #1 reset = 1'b0;
    // Reset held while inputs toggle.
    cyc(1'b1, A_LED, 32'hFFFF_FFFF, 4'hF);
    cyc(1'b1, A_SCRATCH, 32'h1234_5678, 4'hF);
    reset = 1'b1;
    rd_chk("rst_led", A_LED, 32'd0);
    rd_chk("rst_cycle0", A_CYCLE, 32'd0);
    rd_chk("rst_scratch", A_SCRATCH, 32'd0);
    repeat (3) cyc(1'b0, A_CYCLE, 32'd0, 4'd0);
    rd_chk("cycle_after3", A_CYCLE, 32'd3);
    a = 32'h0000_1000; #1;
    check("hit_outside", {31'd0, hit}, 32'd0);

    // Byte lanes on SCRATCH.
    cyc(1'b1, A_SCRATCH, 32'hDEAD_BEEF, 4'b1111);
    cyc(1'b1, A_SCRATCH, 32'h1122_3344, 4'b0101);
    rd_chk("scratch_lanes", A_SCRATCH, 32'hDE22_BE44);
    cyc(1'b1, BASE + 32'h12, 32'hFFFF_FFFF, 4'b1111);
    rd_chk("scratch_misaligned", A_SCRATCH, 32'hDE22_BE44);

    // LED.
    cyc(1'b1, A_LED, 32'h0000_00A5, 4'hF);
    check("led_out", {28'd0, LED}, 32'h5);
    rd_chk("led_rd", A_LED, 32'h5);
    cyc(1'b1, A_LED, 32'hFFFF_FFFF, 4'b1110);
    check("led_hold", {28'd0, LED}, 32'h5);

    // One-shot: COUNT=3 then EN; irq on the 4th edge after the CTRL write edge.
    cyc(1'b1, A_COUNT, 32'd3, 4'hF);
    cyc(1'b1, A_CTRL, 32'h1, 4'hF);
    for (int i = 1; i <= 4; i++) begin
      check("oneshot_irq_pre", {31'd0, irq}, 32'd0);
      cyc(1'b0, A_CTRL, 32'd0, 4'd0);
    end
    check("oneshot_irq", {31'd0, irq}, 32'd1);
    rd_chk("oneshot_ctrl", A_CTRL, 32'h4);
    cyc(1'b1, A_CTRL, 32'h4, 4'hF);
    check("oneshot_clear", {31'd0, irq}, 32'd0);

    // Auto-reload with RELOAD=2.
    cyc(1'b1, A_RELOAD, 32'd2, 4'hF);
    cyc(1'b1, A_COUNT, 32'd0, 4'hF);
    cyc(1'b1, A_CTRL, 32'h3, 4'hF);
    check("auto_f0", {31'd0, irq}, 32'd0);
    cyc(1'b0, A_CTRL, 32'd0, 4'd0);
    check("auto_f1", {31'd0, irq}, 32'd1);
    cyc(1'b1, A_CTRL, 32'h7, 4'hF);
    check("auto_f2_cleared", {31'd0, irq}, 32'd0);
    cyc(1'b0, A_CTRL, 32'd0, 4'd0);
    check("auto_f3", {31'd0, irq}, 32'd0);
    cyc(1'b1, A_CTRL, 32'h7, 4'hF);
    check("auto_clear_vs_expiry", {31'd0, irq}, 32'd1);
    rd_chk("auto_f4_count", A_COUNT, 32'd2);
    cyc(1'b0, A_CTRL, 32'd0, 4'd0);
    cyc(1'b0, A_CTRL, 32'd0, 4'd0);
    cyc(1'b1, A_RELOAD, 32'd5, 4'hF);
    rd_chk("reload_old_used", A_COUNT, 32'd2);
    rd_chk("reload_new", A_RELOAD, 32'd5);

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      int          sel;
      logic [31:0] ad, d;
      sel = $urandom_range(0, 9);
      d   = $urandom;
      if (sel <= 5)      ad = BASE + 32'(sel * 4);
      else if (sel == 6) ad = BASE + 32'h18 + 32'($urandom_range(0, 57) * 4);
      else if (sel == 7) ad = BASE + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(1, 3));
      else if (sel == 8) ad = $urandom;
      else               ad = A_CTRL;
      if (ad == A_COUNT || ad == A_RELOAD) d = 32'($urandom_range(0, 12));
      if (ad == A_CTRL) d = 32'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), ad, d, 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset while the timer is running.
    cyc(1'b1, A_CTRL, 32'h4, 4'hF);
    cyc(1'b1, A_CTRL, 32'h4, 4'hF);
    cyc(1'b1, A_LED, 32'hF, 4'hF);
    cyc(1'b1, A_RELOAD, 32'd100, 4'hF);
    cyc(1'b1, A_COUNT, 32'd0, 4'hF);
    cyc(1'b1, A_CTRL, 32'h3, 4'hF);
    cyc(1'b0, A_CTRL, 32'd0, 4'd0);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    check("pre_rst_led", {28'd0, LED}, 32'hF);
    rd_chk("pre_rst_count", A_COUNT, 32'd100);
    reset = 1'b0;
    #1;
    check("async_rst_count", rd, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    check("async_rst_led", {28'd0, LED}, 32'd0);
    rd_chk("async_rst_ctrl", A_CTRL, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (4) cyc(1'b0, A_COUNT, 32'd0, 4'd0);
    rd_chk("post_rst_count", A_COUNT, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped peripheral responder on the core's data-memory port, in parallel with dmem; the responder side of the core's load/store interface.
- Decodes a 256-byte MMIO window and serves these registers: LED output, scratch, free-running cycle counter, and a down-counting timer with interrupt.
- Top-level muxes the read data from this block or dmem based on `hit`.
- Read timing matches dmem: read data is combinational, writes commit on the rising clock edge.

Parameters:
- BASE_ADDR, 32'h8000_0000, window base; must be 256-byte aligned.
- LED_WIDTH, 4, width of the LED register and output.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- we  input  1  store strobe from the core's memory stage
- byteEnable  input  4  per-byte write enables; bit i covers wd[8i+7:8i]
- a  input  32  byte address (ALU result)
- wd  input  32  store data
- rd  output  32  read data, valid when hit=1
- hit  output  1  a[31:8]==BASE_ADDR[31:8]
- irq  output  1  timer interrupt pending level
- LED  output  LED_WIDTH  LED register contents

Behaviour:
- Reset (reset=0, async): LED=0, SCRATCH=0, CYCLE=0, CTRL=0, COUNT=0, RELOAD=0, so irq=0. rd/hit follow a combinationally.
- Decode: offset=a[7:0]. An access is a register access only if hit=1 and a[1:0]==0. Anything else reads 0 and ignores writes.
- Register map (offset, access, contents):
  - 0x00 LED, RW, bits [LED_WIDTH-1:0]; upper bits read 0.
  - 0x04 CTRL, RW:
    - bit0 EN
    - bit1 AUTO
    - bit2 PEND, write-1-to-clear
    - other bits read 0
  - 0x08 COUNT, RW, 32-bit.
  - 0x0C RELOAD, RW, 32-bit.
  - 0x10 SCRATCH, RW, 32-bit.
  - 0x14 CYCLE, RO, 32-bit; writes ignored.
  - Other offsets: read 0.
- Writes: on the posedge with we=1 and a register access. Only byte lanes with byteEnable[i]=1 update. For CTRL, EN/AUTO/PEND live in byte 0, so byteEnable[0] gates them.
- Read latency: 0 cycles. rd reflects register state before the current edge, so a load in the same cycle as an unrelated write sees the old value.
- CYCLE: increments by 1 every cycle out of reset, wraps 32'hFFFF_FFFF -> 0.
- Timer, evaluated each posedge, priority highest first:
  1. Write to COUNT (any enabled byte): COUNT takes the merged write value; no decrement that cycle.
  2. Else if EN=1 and COUNT==0:
     - PEND set.
     - If AUTO=1: COUNT<=RELOAD.
     - If AUTO=0: EN<=0.
  3. Else if EN=1: COUNT<=COUNT-1.
  4. Else: hold.
- Expiry: with EN=1, AUTO=0 and COUNT=N, expiry (PEND=1) occurs N+1 edges later.
- Reload period: with AUTO=1, PEND is set every RELOAD+1 cycles.
- CTRL write vs expiry in the same cycle:
  - Expiry's PEND set wins over a W1C clear.
  - EN/AUTO take the written value, except that a non-AUTO expiry forces EN=0.
- RELOAD write coincident with auto-reload: the old RELOAD value is loaded.
- irq = PEND (level); it stays high until software clears it.
- Reset asserted mid-count aborts immediately to reset values; there is no pending carry-over.

Decomposition:
- Package mmio_pkg:
  - Register offsets: OFF_LED, OFF_CTRL, OFF_COUNT, OFF_RELOAD, OFF_SCRATCH, OFF_CYCLE.
  - CTRL bit indices: CTRL_EN, CTRL_AUTO, CTRL_PEND.
  - A byte-merge function (old, wd, byteEnable) -> new.
- One sub-module, mmio_timer:
  - Holds COUNT, RELOAD, EN, AUTO and PEND plus the priority logic above.
  - Inputs: decoded write strobes and merged data.
  - Outputs: register values and irq.
- Decode, LED, SCRATCH, CYCLE and the read mux stay in mmio_responder.

Test Plan:
- Reset then reads: hold reset=0 for 2 cycles while toggling inputs. After release, reads return these values, and hit=0 for a=0x0000_1000:
  - 0x8000_0000 -> 0
  - 0x8000_0014 -> cycles since release
- Byte lanes: write 0xDEADBEEF to 0x8000_0010 with byteEnable=4'b1111, then write 0x11223344 with byteEnable=4'b0101. SCRATCH reads 0xDE22BE44. A write to 0x8000_0012 (misaligned) leaves it unchanged.
- LED: write 0x0000_00A5 to 0x8000_0000 -> LED=4'h5, and a read returns 0x5. A write with byteEnable=4'b1110 leaves LED unchanged.
- One-shot timer:
  - Write COUNT=3, then CTRL=0x1.
  - irq rises exactly 4 edges after the CTRL write edge, and EN reads 0.
  - Write CTRL=0x4 -> irq=0 next cycle.
- Auto-reload:
  - Write RELOAD=2, COUNT=0, then CTRL=0x3.
  - PEND sets every 3 cycles.
  - Clear PEND on the same edge as an expiry -> irq stays 1.
  - Write RELOAD=5 on a reload edge -> that reload uses 2.
- Reset mid-operation: with the timer running at COUNT=100, pulse reset low asynchronously between edges. COUNT, CTRL, irq and LED go 0 immediately, with no clock edge required.
